tc_mod7_accumulator: RTL and testbench
======================================

Name: tc_mod7_accumulator

Overview:
- Downstream consumer of the binary-to-thermometer converter in the RNS modulo-7 channel.
- Accepts a stream of 6-bit thermometer-coded residues (value v, 0..6, encoded as the low v bits set) over a valid/ready handshake.
- Accumulates each frame of COUNT operands modulo 7.
- Presents the frame sum in both thermometer and binary form, then waits for downstream acceptance.

Parameters:
- COUNT, 4, number of operands accumulated per frame (legal range 1..255).
- CNT_W, 8, width of the operand counter; must satisfy 2^CNT_W > COUNT.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous frame abort; clears accumulator, counter, state and err.
- in_valid  input  1  in_tc holds an operand.
- in_ready  output  1  block can accept an operand this cycle.
- in_tc  input  6  thermometer-coded residue, bit 1 = LSB, bits [6:1].
- out_valid  output  1  frame result available.
- out_ready  input  1  downstream accepts the result.
- out_tc  output  6  frame sum mod 7, thermometer code, bits [6:1].
- out_bin  output  3  frame sum mod 7, binary (0..6).
- err  output  1  sticky flag: a non-thermometer code was accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = ACCUM, acc = 0, count = 0.
  - out_valid = 0, out_tc = 000000, out_bin = 000, err = 0.
  - in_ready = 1 in the first cycle after release.
- Legal in_tc codes: 000000, 000001, 000011, 000111, 001111, 011111, 111111.
- Accept event: in_valid && in_ready at a rising clk edge.
- State ACCUM:
  - in_ready = 1, out_valid = 0.
  - On accept: acc <= (acc + v) mod 7, where v = in_tc value; count <= count + 1.
  - If the accepted operand is number COUNT of the frame (count == COUNT-1), go to HOLD at that same edge.
- State HOLD:
  - in_ready = 0, out_valid = 1.
  - out_tc and out_bin are registered and reflect the final acc, held stable while out_valid && !out_ready.
  - On out_valid && out_ready: acc <= 0, count <= 0, state <= ACCUM.
  - in_ready = 1 again in the following cycle; there is no same-cycle bypass.
- Latency and throughput:
  - out_valid rises the cycle after the last operand is accepted.
  - Minimum frame period is COUNT + 1 cycles.
- Arithmetic:
  - Sum range before reduction is 0..12; a sum of 7 or more wraps by subtracting 7.
  - A sum of exactly 7 yields 0 (out_tc = 000000).
  - out_bin always equals the popcount of out_tc.
- Illegal in_tc on accept:
  - The operand is treated as value 0; count still increments.
  - err <= 1 and stays set until clear or reset.
- clear:
  - Takes priority over accept and output handshake in the same cycle.
  - Next state is ACCUM with acc = 0, count = 0, out_valid = 0, err = 0.
  - The operand presented in that cycle is discarded.
- Handshake rules:
  - in_valid while in HOLD is not accepted and is not lost; upstream must hold it.
  - out_ready while in ACCUM is ignored.
- Reset mid-frame: the partial sum is discarded and no output is produced.
- COUNT = 1: every accepted operand produces a frame; out_tc equals the operand reduced mod 7, which is the operand itself when legal.

Test Plan:
- Reset, then frame 3,5,6,2 (in_tc 000111, 011111, 111111, 000011) back-to-back -> sum 16 mod 7 = 2; out_tc=000011, out_bin=2; out_valid rises one cycle after the 4th accept.
- Frame 0,0,0,0 -> out_tc=000000, out_bin=0. Then frame 1,6,0,0 -> sum 7 wraps to 0, out_tc=000000. Then frame 6,6,6,6 -> 24 mod 7 = 3, out_tc=000111.
- Hold out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, out_tc stable, no operand consumed. Raise out_ready -> next frame starts the following cycle, accumulating from 0.
- Inject in_tc=000101 as the 2nd of 4, with the others 4,4,4 -> result 12 mod 7 = 5 (out_tc=011111), err=1 remains set through the next clean frame; clear deasserts err.
- Assert clear after 2 of 4 operands (1,2) -> next frame 3,3,3,3 gives 12 mod 7 = 5, with no residue from the aborted frame. Drive rst_n low asynchronously in HOLD -> out_valid drops immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tc_mod7_accumulator.sv
// Modulo-7 frame accumulator for thermometer-coded residues in the RNS mod-7 channel.
// Sums COUNT operands per frame, then holds the result until the consumer accepts it.
module tc_mod7_accumulator #(
    parameter int COUNT = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:1] in_tc,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [6:1] out_tc,
    output logic [2:0] out_bin,
    output logic       err
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state_q, state_d;
    logic [2:0]       acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [6:1]       out_tc_q;
    logic [3:0]       dec;

    // Returns {legal, value}; anything that is not a run of low ones is illegal.
    function automatic logic [3:0] tc_decode(input logic [6:1] code);
        case (code)
            6'b000000: return 4'b1_000;
            6'b000001: return 4'b1_001;
            6'b000011: return 4'b1_010;
            6'b000111: return 4'b1_011;
            6'b001111: return 4'b1_100;
            6'b011111: return 4'b1_101;
            6'b111111: return 4'b1_110;
            default:   return 4'b0_000;
        endcase
    endfunction

    function automatic logic [2:0] mod7_add(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 4'd7) s = s - 4'd7;
        return s[2:0];
    endfunction

    function automatic logic [6:1] to_therm(input logic [2:0] v);
        logic [6:0] t;
        t = (7'd1 << v) - 7'd1;
        return t[5:0];
    endfunction

    assign dec       = tc_decode(in_tc);
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_tc    = out_tc_q;
    assign out_bin   = acc_q;
    assign err       = err_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (clear) begin
            state_d = ACCUM;
            acc_d   = 3'd0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        // Illegal codes contribute zero but still count as an operand.
                        acc_d = mod7_add(acc_q, dec[3] ? dec[2:0] : 3'd0);
                        cnt_d = cnt_q + CNT_W'(1);
                        if (!dec[3]) err_d = 1'b1;
                        if (cnt_q == CNT_W'(COUNT - 1)) state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        acc_d   = 3'd0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ACCUM;
            acc_q    <= 3'd0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            out_tc_q <= 6'b000000;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            out_tc_q <= to_therm(acc_d);
        end
    end

endmodule

// File: tb/tb_tc_mod7_accumulator.sv
// Directed bench for tc_mod7_accumulator with COUNT = 4.
module tb_tc_mod7_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [6:1] in_tc = 6'b000000;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [6:1] out_tc;
    logic [2:0] out_bin;
    logic       err;

    int checks = 0;
    int errors = 0;

    tc_mod7_accumulator #(.COUNT(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_tc(in_tc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tc(out_tc), .out_bin(out_bin), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:1] tc(input int v);
        logic [6:0] t;
        t = (7'd1 << v) - 7'd1;
        return t[5:0];
    endfunction

    task automatic push_raw(input logic [6:1] code);
        in_valid = 1'b1;
        in_tc    = code;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic push(input int v);
        push_raw(tc(v));
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_tc !== 6'b000000) begin errors++; $display("FAIL rst_out_tc: got %b expected 000000", out_tc); end
        checks++; if (out_bin !== 3'd0) begin errors++; $display("FAIL rst_out_bin: got %0d expected 0", out_bin); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        push(3); push(5); push(6);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early_valid: got %b expected 0", out_valid); end
        push(2);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_tc !== 6'b000011) begin errors++; $display("FAIL b2b_out_tc: got %b expected 000011", out_tc); end
        checks++; if (out_bin !== 3'd2) begin errors++; $display("FAIL b2b_out_bin: got %0d expected 2", out_bin); end
        ack();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_ack_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ack_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_wrap();
        push(0); push(0); push(0); push(0);
        checks++; if (out_tc !== 6'b000000 || out_bin !== 3'd0 || out_valid !== 1'b1)
            begin errors++; $display("FAIL zero_frame: got tc=%b bin=%0d v=%b expected 000000 0 1", out_tc, out_bin, out_valid); end
        ack();
        push(1); push(6); push(0); push(0);
        checks++; if (out_tc !== 6'b000000 || out_bin !== 3'd0 || out_valid !== 1'b1)
            begin errors++; $display("FAIL wrap7_frame: got tc=%b bin=%0d v=%b expected 000000 0 1", out_tc, out_bin, out_valid); end
        ack();
        push(6); push(6); push(6); push(6);
        checks++; if (out_tc !== 6'b000111 || out_bin !== 3'd3 || out_valid !== 1'b1)
            begin errors++; $display("FAIL max_frame: got tc=%b bin=%0d v=%b expected 000111 3 1", out_tc, out_bin, out_valid); end
        ack();
    endtask

    task automatic test_stall();
        push(1); push(1); push(1); push(1);
        in_valid = 1'b1;
        in_tc    = tc(2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tc !== 6'b001111)
                begin errors++; $display("FAIL stall_hold[%0d]: got rdy=%b v=%b tc=%b expected 0 1 001111", i, in_ready, out_valid, out_tc); end
        end
        ack();
        in_valid = 1'b1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL stall_release: got rdy=%b v=%b expected 1 0", in_ready, out_valid); end
        push(2); push(2); push(2); push(2);
        checks++; if (out_tc !== 6'b000001 || out_bin !== 3'd1 || out_valid !== 1'b1)
            begin errors++; $display("FAIL stall_next_frame: got tc=%b bin=%0d v=%b expected 000001 1 1", out_tc, out_bin, out_valid); end
        ack();
    endtask

    task automatic test_illegal();
        push(4);
        push_raw(6'b000101);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err_set: got %b expected 1", err); end
        push(4); push(4);
        checks++; if (out_tc !== 6'b011111 || out_bin !== 3'd5 || out_valid !== 1'b1)
            begin errors++; $display("FAIL illegal_frame: got tc=%b bin=%0d v=%b expected 011111 5 1", out_tc, out_bin, out_valid); end
        ack();
        push(0); push(0); push(0); push(1);
        checks++; if (out_tc !== 6'b000001 || err !== 1'b1)
            begin errors++; $display("FAIL illegal_sticky: got tc=%b err=%b expected 000001 1", out_tc, err); end
        ack();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL illegal_clear_err: got %b expected 0", err); end
    endtask

    task automatic test_clear();
        push(1); push(2);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_tc    = tc(6);
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_bin !== 3'd0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL clear_state: got bin=%0d v=%b expected 0 0", out_bin, out_valid); end
        push(3); push(3); push(3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_count: got v=%b expected 0", out_valid); end
        push(3);
        checks++; if (out_tc !== 6'b011111 || out_bin !== 3'd5 || out_valid !== 1'b1)
            begin errors++; $display("FAIL clear_next_frame: got tc=%b bin=%0d v=%b expected 011111 5 1", out_tc, out_bin, out_valid); end
        ack();
    endtask

    task automatic test_async_reset();
        push(1); push(1); push(1); push(1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b expected 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_tc !== 6'b000000 || in_ready !== 1'b1)
            begin errors++; $display("FAIL arst_drop: got v=%b tc=%b rdy=%b expected 0 000000 1", out_valid, out_tc, in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(2); push(2); push(2); push(2);
        checks++; if (out_tc !== 6'b000001 || out_valid !== 1'b1)
            begin errors++; $display("FAIL arst_next_frame: got tc=%b v=%b expected 000001 1", out_tc, out_valid); end
        ack();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wrap();
        test_stall();
        test_illegal();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
